// File: rtl/seq_repeat_pkg.sv
// rtl/seq_repeat_pkg.sv - shared types and window helper for the repetition monitor
package seq_repeat_pkg;

  typedef enum logic [1:0] {
    REP_CONSEC    = 2'd0,
    REP_GOTO      = 2'd1,
    REP_NONCONSEC = 2'd2,
    REP_ILLEGAL   = 2'd3
  } rep_mode_e;

  localparam int BOUND_W = 32;

  // hi == 0 encodes an unbounded upper limit
  function automatic logic in_window(input logic [BOUND_W:0]   x,
                                     input logic [BOUND_W-1:0] lo,
                                     input logic [BOUND_W-1:0] hi);
    return (x >= {1'b0, lo}) && ((hi == '0) || (x <= {1'b0, hi}));
  endfunction

endpackage

// File: rtl/seq_repeat_monitor_if.sv
// rtl/seq_repeat_monitor_if.sv - control/event/status bundle for seq_repeat_monitor
interface seq_repeat_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic                    en;
  logic [1:0]              mode;
  logic [CNT_W-1:0]        min_rep;
  logic [CNT_W-1:0]        max_rep;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       ev;
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       ovf;
  logic                    cfg_err;

  modport master (
    output en, mode, min_rep, max_rep, clr, ev,
    input  hit, count, ovf, cfg_err
  );

  modport slave (
    input  en, mode, min_rep, max_rep, clr, ev,
    output hit, count, ovf, cfg_err
  );
endinterface

// File: rtl/seq_repeat_ch.sv
// rtl/seq_repeat_ch.sv - one monitor channel: counter, sticky overflow and window match
module seq_repeat_ch
  import seq_repeat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] min_rep,
  input  logic [CNT_W-1:0] max_rep,
  input  logic             clr,
  input  logic             ev,
  output logic             hit,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   nxt;
  logic             bounded, restart, saturated, locked, ev_eff;
  logic             win_nxt, win_cur;

  always_comb begin
    nxt       = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    bounded   = (max_rep != '0);
    restart   = bounded && (nxt == {1'b0, max_rep});
    saturated = !bounded && (&count_q);
    // a completed non-consecutive window parks at max_rep until cleared
    locked    = (mode == REP_NONCONSEC) && bounded && (count_q == max_rep);
    ev_eff    = ev && !locked;
    win_nxt   = in_window((BOUND_W+1)'(nxt), BOUND_W'(min_rep), BOUND_W'(max_rep));
    win_cur   = in_window((BOUND_W+1)'(count_q), BOUND_W'(min_rep), BOUND_W'(max_rep));

    count_d = count_q;
    ovf_d   = ovf_q;
    hit     = 1'b0;

    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (!active) begin
      count_d = '0;
    end else if (ev_eff) begin
      hit = win_nxt;
      if (saturated) begin
        ovf_d = 1'b1;
      end else if (restart) begin
        count_d = (mode == REP_NONCONSEC) ? max_rep : '0;
      end else begin
        count_d = nxt[CNT_W-1:0];
      end
    end else begin
      if (mode == REP_CONSEC) begin
        count_d = '0;
      end
      if (mode == REP_NONCONSEC) begin
        hit = (count_q != '0) && win_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/seq_repeat_monitor.sv
// rtl/seq_repeat_monitor.sv - multi-channel SVA-style repetition window monitor
module seq_repeat_monitor
  import seq_repeat_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_repeat_monitor_if.slave bus
);

  logic cfg_err;
  logic active;

  always_comb begin
    cfg_err = (bus.mode == REP_ILLEGAL) ||
              (bus.min_rep == '0) ||
              ((bus.max_rep != '0) && (bus.min_rep > bus.max_rep));
    active  = bus.en && !cfg_err;
  end

  assign bus.cfg_err = cfg_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seq_repeat_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .active  (active),
      .mode    (bus.mode),
      .min_rep (bus.min_rep),
      .max_rep (bus.max_rep),
      .clr     (bus.clr[i]),
      .ev      (bus.ev[i]),
      .hit     (bus.hit[i]),
      .count   (bus.count[i*CNT_W +: CNT_W]),
      .ovf     (bus.ovf[i])
    );
  end

endmodule

// File: tb/tb_seq_repeat_monitor.sv
// tb/tb_seq_repeat_monitor.sv - directed scoreboard bench for seq_repeat_monitor
module tb_seq_repeat_monitor;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_repeat_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  seq_repeat_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  hit;
    logic [15:0] cnt;
    logic [3:0]  ovf;
    logic        cerr;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       en_v, rst_v;
  logic [1:0] m_v;
  logic [3:0] mn_v, mx_v;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // outputs sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.nm, "hit",     32'(bus.hit),     32'(mon_e.hit));
      chk(mon_e.nm, "count",   32'(bus.count),   32'(mon_e.cnt));
      chk(mon_e.nm, "ovf",     32'(bus.ovf),     32'(mon_e.ovf));
      chk(mon_e.nm, "cfg_err", 32'(bus.cfg_err), 32'(mon_e.cerr));
    end
  end

  task automatic drive(input logic [3:0] ev, input logic [3:0] clr);
    @(posedge clk);
    #1;
    bus.en      = en_v;
    bus.mode    = m_v;
    bus.min_rep = mn_v;
    bus.max_rep = mx_v;
    bus.ev      = ev;
    bus.clr     = clr;
    rst         = rst_v;
  endtask

  task automatic step(input logic [3:0] ev, input logic [3:0] clr, input logic [3:0] hit,
                      input logic [15:0] cnt, input logic [3:0] ovf, input logic cerr,
                      input string nm);
    exp_t e;
    drive(ev, clr);
    e.hit = hit; e.cnt = cnt; e.ovf = ovf; e.cerr = cerr; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic cfg(input logic [1:0] m, input logic [3:0] mn, input logic [3:0] mx);
    en_v = 1'b0; m_v = m; mn_v = mn; mx_v = mx;
    drive(4'h0, 4'hf);
    en_v = 1'b1;
    drive(4'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 2'd0; bus.min_rep = 4'd1; bus.max_rep = 4'd0;
    bus.clr = 4'h0; bus.ev = 4'h0;
    en_v = 1'b0; m_v = 2'd0; mn_v = 4'd1; mx_v = 4'd0; rst_v = 1'b1;

    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "reset");
    rst_v = 1'b0;

    // consecutive, window [5:5]
    cfg(2'd0, 4'd5, 4'd5);
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "con1");
    step(4'h1, 4'h0, 4'h0, 16'h0001, 4'h0, 1'b0, "con2");
    step(4'h1, 4'h0, 4'h0, 16'h0002, 4'h0, 1'b0, "con3");
    step(4'h1, 4'h0, 4'h0, 16'h0003, 4'h0, 1'b0, "con4");
    step(4'h1, 4'h0, 4'h1, 16'h0004, 4'h0, 1'b0, "con5");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "con_restart");
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "con4a");
    step(4'h1, 4'h0, 4'h0, 16'h0001, 4'h0, 1'b0, "con4b");
    step(4'h1, 4'h0, 4'h0, 16'h0002, 4'h0, 1'b0, "con4c");
    step(4'h1, 4'h0, 4'h0, 16'h0003, 4'h0, 1'b0, "con4d");
    step(4'h0, 4'h0, 4'h0, 16'h0004, 4'h0, 1'b0, "con_gap");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "con_zero");

    // goto, window [2:3]
    cfg(2'd1, 4'd2, 4'd3);
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "goto1");
    step(4'h0, 4'h0, 4'h0, 16'h0001, 4'h0, 1'b0, "goto2");
    step(4'h0, 4'h0, 4'h0, 16'h0001, 4'h0, 1'b0, "goto3");
    step(4'h1, 4'h0, 4'h1, 16'h0001, 4'h0, 1'b0, "goto4");
    step(4'h0, 4'h0, 4'h0, 16'h0002, 4'h0, 1'b0, "goto5");
    step(4'h1, 4'h0, 4'h1, 16'h0002, 4'h0, 1'b0, "goto6");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "goto7");

    // non-consecutive, window [2:3]
    cfg(2'd2, 4'd2, 4'd3);
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "nc1");
    step(4'h0, 4'h0, 4'h0, 16'h0001, 4'h0, 1'b0, "nc2");
    step(4'h1, 4'h0, 4'h1, 16'h0001, 4'h0, 1'b0, "nc3");
    step(4'h0, 4'h0, 4'h1, 16'h0002, 4'h0, 1'b0, "nc4");
    step(4'h0, 4'h0, 4'h1, 16'h0002, 4'h0, 1'b0, "nc5");
    step(4'h1, 4'h0, 4'h1, 16'h0002, 4'h0, 1'b0, "nc6");
    step(4'h1, 4'h0, 4'h1, 16'h0003, 4'h0, 1'b0, "nc_locked");
    step(4'h0, 4'h0, 4'h1, 16'h0003, 4'h0, 1'b0, "nc_hold");
    step(4'h0, 4'h1, 4'h0, 16'h0003, 4'h0, 1'b0, "nc_clr");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "nc_after");

    // unbounded non-consecutive, saturation
    cfg(2'd2, 4'd1, 4'd0);
    for (int i = 0; i < 16; i++)
      step(4'h1, 4'h0, 4'h1, 16'(i), 4'h0, 1'b0, "sat_run");
    step(4'h0, 4'h0, 4'h1, 16'h000f, 4'h1, 1'b0, "sat_idle");
    step(4'h1, 4'h0, 4'h1, 16'h000f, 4'h1, 1'b0, "sat_ev");
    step(4'h0, 4'h1, 4'h0, 16'h000f, 4'h1, 1'b0, "sat_clr");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "sat_after");

    // configuration errors and enable
    cfg(2'd1, 4'd1, 4'd0);
    step(4'h1, 4'h0, 4'h1, 16'h0000, 4'h0, 1'b0, "cfg_a");
    step(4'h1, 4'h0, 4'h1, 16'h0001, 4'h0, 1'b0, "cfg_b");
    m_v = 2'd3;
    step(4'h1, 4'h0, 4'h0, 16'h0002, 4'h0, 1'b1, "cfg_mode3");
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, "cfg_mode3b");
    m_v = 2'd1; mn_v = 4'd0;
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, "cfg_min0");
    mn_v = 4'd4; mx_v = 4'd2;
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b1, "cfg_inv");
    mn_v = 4'd2; mx_v = 4'd4;
    step(4'h1, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "cfg_ok1");
    step(4'h1, 4'h0, 4'h1, 16'h0001, 4'h0, 1'b0, "cfg_ok2");
    en_v = 1'b0;
    step(4'h1, 4'h0, 4'h0, 16'h0002, 4'h0, 1'b0, "en_off");
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "en_off2");

    // async reset mid-count and channel independence
    cfg(2'd1, 4'd1, 4'd0);
    step(4'h1, 4'h0, 4'h1, 16'h0000, 4'h0, 1'b0, "rst1");
    step(4'h1, 4'h0, 4'h1, 16'h0001, 4'h0, 1'b0, "rst2");
    step(4'h1, 4'h0, 4'h1, 16'h0002, 4'h0, 1'b0, "rst3");
    step(4'h0, 4'h0, 4'h0, 16'h0003, 4'h0, 1'b0, "rst_pre");
    rst_v = 1'b1;
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "rst_async");
    rst_v = 1'b0;
    step(4'h0, 4'h0, 4'h0, 16'h0000, 4'h0, 1'b0, "rst_rel");
    step(4'h1, 4'h0, 4'h1, 16'h0000, 4'h0, 1'b0, "rst_ev");
    step(4'h5, 4'h0, 4'h5, 16'h0001, 4'h0, 1'b0, "indep1");
    step(4'h0, 4'h0, 4'h0, 16'h0102, 4'h0, 1'b0, "indep2");

    @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
